// File: rtl/otter_intr_arbiter_if.sv
// IOBUS register-access bundle between the OTTER_MCU and the interrupt arbiter.
// The CPU drives address/data/strobe; the arbiter returns read data and a hit flag.
interface otter_intr_arbiter_if;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] rd_data;
    logic        rd_hit;

    modport master (
        output iobus_addr,
        output iobus_out,
        output iobus_wr,
        input  rd_data,
        input  rd_hit
    );

    modport slave (
        input  iobus_addr,
        input  iobus_out,
        input  iobus_wr,
        output rd_data,
        output rd_hit
    );
endinterface

// File: rtl/otter_intr_arbiter.sv
// Interrupt arbiter/sequencer sharing the single OTTER_MCU INTR line among N_SRC sources:
// per-source edge capture into PENDING, MASK gating, fixed-width INTR pulse, then hold-off until ACK.
module otter_intr_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1100_E000,
    parameter int unsigned INTR_PW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    otter_intr_arbiter_if.slave bus,
    output logic             intr
);
    localparam int unsigned CNT_W     = 4;
    localparam logic [31:0] PEND_ADDR = BASE_ADDR;
    localparam logic [31:0] MASK_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] ACK_ADDR  = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   hist_q, hist_d;
    logic               intr_q, intr_d;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   active;
    logic               pend_wr, mask_wr, ack_wr;
    logic [31:0]        claim;
    logic               unused_wdata;

    assign rise    = src_in & ~hist_q;
    assign active  = pending_q & mask_q;
    assign pend_wr = bus.iobus_wr && (bus.iobus_addr == PEND_ADDR);
    assign mask_wr = bus.iobus_wr && (bus.iobus_addr == MASK_ADDR);
    assign ack_wr  = bus.iobus_wr && (bus.iobus_addr == ACK_ADDR);
    assign intr    = intr_q;
    assign unused_wdata = ^bus.iobus_out[31:5];

    // Hist resets to all ones so a source already high at reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            hist_q    <= '1;
            intr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            hist_q    <= hist_d;
            intr_q    <= intr_d;
        end
    end

    // Sequencer plus register updates; a new edge wins over a same-cycle clear.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        mask_d    = mask_q;
        hist_d    = src_in;
        intr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(INTR_PW);
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(1)) state_d = WAIT_ACK;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            WAIT_ACK: begin
                if (ack_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        intr_d = (state_d == PULSE);

        for (int i = 0; i < int'(N_SRC); i++) begin
            if (rise[i])                                         pending_d[i] = 1'b1;
            else if (pend_wr && bus.iobus_out[i])                pending_d[i] = 1'b0;
            else if (ack_wr && (bus.iobus_out[4:0] == 5'(i)))    pending_d[i] = 1'b0;
        end

        if (mask_wr) mask_d = bus.iobus_out[N_SRC-1:0];
    end

    // Lowest-index active source wins the claim.
    always_comb begin
        claim = 32'hFFFF_FFFF;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (active[i]) claim = 32'(i);
        end
    end

    // Side-effect-free read mux; zero when not addressed so it can be OR-ed onto IOBUS_IN.
    always_comb begin
        bus.rd_hit  = 1'b0;
        bus.rd_data = 32'd0;
        if (bus.iobus_addr == PEND_ADDR) begin
            bus.rd_hit  = 1'b1;
            bus.rd_data = 32'(pending_q);
        end else if (bus.iobus_addr == MASK_ADDR) begin
            bus.rd_hit  = 1'b1;
            bus.rd_data = 32'(mask_q);
        end else if (bus.iobus_addr == ACK_ADDR) begin
            bus.rd_hit  = 1'b1;
            bus.rd_data = claim;
        end
    end
endmodule

// File: tb/tb_otter_intr_arbiter.sv
// Bench for otter_intr_arbiter: directed scenarios then random traffic, all checked
// each cycle against a behavioural model of pending events and INTR service phases.
module tb_otter_intr_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned PW   = 3;
    localparam logic [31:0] BASE = 32'h1100_E000;
    localparam logic [31:0] UNMAPPED = 32'h1100_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src_in;
    logic         intr;

    otter_intr_arbiter_if bus ();

    otter_intr_arbiter #(.N_SRC(N), .BASE_ADDR(BASE), .INTR_PW(PW)) dut (
        .clk    (clk),
        .reset  (reset),
        .src_in (src_in),
        .bus    (bus.slave),
        .intr   (intr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: event flags per source, mask, last input, and where we are in servicing.
    bit [N-1:0] m_pend, m_mask, m_hist;
    int         m_high_left;   // remaining INTR-high cycles, 0 when not pulsing
    bit         m_need_ack;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_claim();
        for (int i = 0; i < int'(N); i++)
            if (m_pend[i] && m_mask[i]) return 32'(i);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [32:0] m_read(input logic [31:0] a);
        if (a == BASE)        return {1'b1, 32'(m_pend)};
        if (a == BASE + 32'd4) return {1'b1, 32'(m_mask)};
        if (a == BASE + 32'd8) return {1'b1, m_claim()};
        return 33'd0;
    endfunction

    task automatic model_step();
        bit [N-1:0] np;
        bit         ack;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_hist = '1; m_high_left = 0; m_need_ack = 1'b0;
            return;
        end
        ack = bus.iobus_wr && (bus.iobus_addr == BASE + 32'd8);
        if (m_high_left > 0) begin
            m_high_left--;
            if (m_high_left == 0) m_need_ack = 1'b1;
        end else if (m_need_ack) begin
            if (ack) m_need_ack = 1'b0;
        end else if ((m_pend & m_mask) != 0) begin
            m_high_left = PW;
        end
        np = m_pend;
        for (int i = 0; i < int'(N); i++) begin
            if (src_in[i] && !m_hist[i]) np[i] = 1'b1;
            else if (bus.iobus_wr && bus.iobus_addr == BASE && bus.iobus_out[i]) np[i] = 1'b0;
            else if (ack && int'(bus.iobus_out[4:0]) == i) np[i] = 1'b0;
        end
        m_pend = np;
        if (bus.iobus_wr && bus.iobus_addr == BASE + 32'd4) m_mask = bus.iobus_out[N-1:0];
        m_hist = src_in;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cyc(input string tag);
        logic [32:0] r;
        @(negedge clk);
        r = m_read(bus.iobus_addr);
        check_val({tag, ":intr"}, 32'(intr), 32'(m_high_left > 0));
        check_val({tag, ":hit"},  32'(bus.rd_hit), 32'(r[32]));
        check_val({tag, ":rd"},   bus.rd_data, r[31:0]);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag);
    endtask

    task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        bus.iobus_addr = a; bus.iobus_out = d; bus.iobus_wr = 1'b1;
        cyc(tag);
        bus.iobus_wr = 1'b0; bus.iobus_addr = BASE + 32'd8;
    endtask

    initial begin
        reset = 1'b1; src_in = 4'b0001;
        bus.iobus_addr = BASE; bus.iobus_out = 32'd0; bus.iobus_wr = 1'b0;
        @(posedge clk); model_step(); #1;

        // Source held high through reset must not create an event.
        cycles("t1_rst", 2);
        reset = 1'b0;
        cycles("t1_hold", 20);
        check_val("t1_pend", bus.rd_data, 32'd0);
        src_in = 4'b0000;
        cycles("t1_rel", 2);

        // Single event, pulse, claim, ack.
        bus_write("t2_mask", BASE + 32'd4, 32'hF);
        src_in = 4'b0100;
        cyc("t2_edge");
        src_in = 4'b0000;
        cycles("t2_pulse", 6);
        check_val("t2_claim", bus.rd_data, 32'd2);
        bus_write("t2_ack", BASE + 32'd8, 32'd2);
        cycles("t2_post", 4);

        // Simultaneous events, priority, back-to-back service.
        src_in = 4'b1010;
        cyc("t3_edge");
        src_in = 4'b0000;
        cycles("t3_p1", 6);
        check_val("t3_claim1", bus.rd_data, 32'd1);
        bus_write("t3_ack1", BASE + 32'd8, 32'd1);
        cycles("t3_p2", 6);
        check_val("t3_claim3", bus.rd_data, 32'd3);
        bus_write("t3_ack3", BASE + 32'd8, 32'd3);
        cycles("t3_post", 2);
        check_val("t3_claim_none", bus.rd_data, 32'hFFFF_FFFF);

        // Masked event, then unmask; W1C does not release the hold-off.
        bus_write("t4_mask0", BASE + 32'd4, 32'h0);
        src_in = 4'b0001;
        cyc("t4_edge");
        src_in = 4'b0000;
        cycles("t4_masked", 6);
        check_val("t4_intr_masked", 32'(intr), 32'd0);
        bus_write("t4_mask1", BASE + 32'd4, 32'h1);
        cycles("t4_pulse", 6);
        bus_write("t4_w1c", BASE, 32'h1);
        bus.iobus_addr = BASE;
        cycles("t4_wait", 4);
        check_val("t4_pend_clr", bus.rd_data, 32'd0);
        bus_write("t4_ack", BASE + 32'd8, 32'd0);
        cycles("t4_post", 3);

        // New edge beats same-cycle ACK clear; unmapped read.
        src_in = 4'b0001;
        bus_write("t5_race", BASE + 32'd8, 32'd0);
        bus.iobus_addr = BASE;
        cyc("t5_after");
        check_val("t5_pend", bus.rd_data, 32'd1);
        bus.iobus_addr = UNMAPPED;
        cyc("t5_unmapped");
        check_val("t5_hit", 32'(bus.rd_hit), 32'd0);
        check_val("t5_rd",  bus.rd_data, 32'd0);
        src_in = 4'b0000;
        cycles("t5_pulse", 5);
        bus_write("t5_ack", BASE + 32'd8, 32'd0);
        cycles("t5_post", 3);

        // Reset during the second pulse cycle.
        bus_write("t6_mask", BASE + 32'd4, 32'hF);
        src_in = 4'b0100;
        cyc("t6_edge");
        src_in = 4'b0000;
        cyc("t6_enter");
        cyc("t6_pw1");
        reset = 1'b1;
        cyc("t6_rst");
        reset = 1'b0;
        check_val("t6_intr", 32'(intr), 32'd0);
        bus.iobus_addr = BASE + 32'd4;
        cyc("t6_mask_rd");
        check_val("t6_mask0", bus.rd_data, 32'd0);
        bus.iobus_addr = BASE;
        cyc("t6_pend_rd");
        check_val("t6_pend0", bus.rd_data, 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < int'(N); i++)
                if ($urandom_range(0, 5) == 0) src_in[i] = ~src_in[i];
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: bus.iobus_addr = BASE;
                1: bus.iobus_addr = BASE + 32'd4;
                2: bus.iobus_addr = BASE + 32'd8;
                default: bus.iobus_addr = BASE + 32'(4 * $urandom_range(3, 8));
            endcase
            bus.iobus_wr = ($urandom_range(0, 3) == 0);
            if (sel == 2) bus.iobus_out = {$urandom_range(0, 1) == 0 ? 27'd0 : 27'($urandom), 5'($urandom_range(0, 7))};
            else          bus.iobus_out = $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 0) bus.iobus_out = 32'hF | ($urandom & 32'hFFFF_FFF0);
            cyc("rnd");
        end
        bus.iobus_wr = 1'b0;
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
